// File: rtl/pxi_pkg.sv
// Shared definitions for the PXI 1-bit write-line receivers.
package pxi_pkg;

   localparam int WORD_W_DEF  = 16;
   localparam int IDLE_TO_DEF = 1024;
   localparam int TO_W_DEF    = 11;

   // Frame assembly states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/pxi_sync_edge.sv
// Two-flop synchronizer for a strobe/data pair with strobe rising-edge
// detection. The data bit is delayed by the same number of flops as the
// strobe, so bit_data is the value synchronized alongside the strobe edge.
module pxi_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic ser_data,
   input  logic ser_strobe,
   output logic rise,
   output logic bit_data
);

   logic strobe_s1, strobe_s2, strobe_s3;
   logic data_s1, data_s2;

   // Synchronize both lines and register the strobe rising edge with its data bit
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_s1 <= 1'b0;
         strobe_s2 <= 1'b0;
         strobe_s3 <= 1'b0;
         data_s1   <= 1'b0;
         data_s2   <= 1'b0;
         rise      <= 1'b0;
         bit_data  <= 1'b0;
      end else begin
         strobe_s1 <= ser_strobe;
         strobe_s2 <= strobe_s1;
         strobe_s3 <= strobe_s2;
         data_s1   <= ser_data;
         data_s2   <= data_s1;
         rise      <= strobe_s2 & ~strobe_s3;
         bit_data  <= data_s2;
      end
   end

endmodule

// File: rtl/pxi_ser_deser.sv
// PXI 1-bit write-line deserializer: assembles WORD_W strobed bits into a
// word and presents it on a single-entry valid/ready output register.
// Partial frames are dropped after IDLE_TO idle cycles; a completed word
// that finds the output register occupied sets the sticky overrun flag.
module pxi_ser_deser
   import pxi_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int MSB_FIRST = 1,
   parameter int IDLE_TO   = IDLE_TO_DEF,
   parameter int TO_W      = TO_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_data,
   input  logic              ser_strobe,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(WORD_W + 1);

   logic              rise;
   logic              bit_data;
   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [TO_W-1:0]   to_cnt;
   logic [WORD_W-1:0] shreg;

   // Place one new bit into the word according to the bit order
   function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sh,
                                                  input logic b);
      if (MSB_FIRST != 0)
         return {sh[WORD_W-2:0], b};
      else
         return {b, sh[WORD_W-1:1]};
   endfunction

   pxi_sync_edge u_sync (
      .clk        (clk),
      .rst        (rst),
      .ser_data   (ser_data),
      .ser_strobe (ser_strobe),
      .rise       (rise),
      .bit_data   (bit_data)
   );

   // Frame assembly FSM with the output register and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         to_cnt     <= '0;
         shreg      <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         // A consumer accept frees the register; a DONE load below may refill it
         if (word_valid && word_ready)
            word_valid <= 1'b0;

         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (rise) begin
                  shreg <= shift_in('0, bit_data);
                  count <= CNT_W'(1);
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end

            SHIFT: begin
               if (rise) begin
                  shreg  <= shift_in(shreg, bit_data);
                  count  <= count + CNT_W'(1);
                  to_cnt <= '0;
                  if (count == CNT_W'(WORD_W - 1))
                     state <= DONE;
               end else if (to_cnt == TO_W'(IDLE_TO - 1)) begin
                  frame_err <= 1'b1;
                  shreg     <= '0;
                  count     <= '0;
                  to_cnt    <= '0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            DONE: begin
               to_cnt <= '0;
               if (!word_valid || word_ready) begin
                  word_out   <= shreg;
                  word_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
               // An edge landing here starts the next frame immediately
               if (rise) begin
                  shreg <= shift_in('0, bit_data);
                  count <= CNT_W'(1);
                  state <= SHIFT;
                  busy  <= 1'b1;
               end else begin
                  shreg <= '0;
                  count <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pxi_ser_deser.sv
// Self-checking bench for pxi_ser_deser: an MSB-first and an LSB-first
// instance share the same serial line and handshake.
module tb_pxi_ser_deser;

   logic        clk = 1'b0;
   logic        rst;
   logic        ser_data;
   logic        ser_strobe;
   logic        ready_drv;
   logic        ready_rnd = 1'b0;
   logic        rand_mode;
   logic        word_ready;
   logic [15:0] out_m, out_l;
   logic        valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l, busy_m, busy_l;

   int comps = 0;
   int fails = 0;
   int fe_m  = 0;
   int fe_l  = 0;
   logic [15:0] q_m[$];
   logic [15:0] q_l[$];

   typedef struct {
      logic [15:0] word;
      int          period;
      logic [15:0] exp_m;
      logic [15:0] exp_l;
   } vec_t;
   vec_t vecs[6];

   assign word_ready = rand_mode ? ready_rnd : ready_drv;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 ready_rnd = 1'($urandom_range(0, 1));
   end

   pxi_ser_deser #(.WORD_W(16), .MSB_FIRST(1), .IDLE_TO(1024), .TO_W(11)) dut_m (
      .clk(clk), .rst(rst), .ser_data(ser_data), .ser_strobe(ser_strobe),
      .word_out(out_m), .word_valid(valid_m), .word_ready(word_ready),
      .frame_err(ferr_m), .overrun(ovr_m), .busy(busy_m));

   pxi_ser_deser #(.WORD_W(16), .MSB_FIRST(0), .IDLE_TO(1024), .TO_W(11)) dut_l (
      .clk(clk), .rst(rst), .ser_data(ser_data), .ser_strobe(ser_strobe),
      .word_out(out_l), .word_valid(valid_l), .word_ready(word_ready),
      .frame_err(ferr_l), .overrun(ovr_l), .busy(busy_l));

   // Record accepted words and frame_err pulses away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_m && word_ready) q_m.push_back(out_m);
         if (valid_l && word_ready) q_l.push_back(out_l);
         if (ferr_m) fe_m++;
         if (ferr_l) fe_l++;
      end
   end

   function automatic logic [15:0] bitrev(input logic [15:0] w);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = w[15-i];
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      comps++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int period);
      int hi;
      hi = period / 2;
      ser_data = b;
      tick(1);
      ser_strobe = 1'b1;
      tick(hi);
      ser_strobe = 1'b0;
      tick(period - 1 - hi);
   endtask

   task automatic send_bits(input logic [15:0] w, input int nbits, input int period);
      for (int i = 15; i > 15 - nbits; i--) send_bit(w[i], period);
   endtask

   task automatic expect_word(input string name, input logic [15:0] em, input logic [15:0] el);
      int t;
      t = 0;
      while ((q_m.size() == 0 || q_l.size() == 0) && t < 300) begin
         tick(1);
         t++;
      end
      if (q_m.size() == 0 || q_l.size() == 0) begin
         comps++;
         fails++;
         $display("FAIL %s: no word delivered within 300 cycles, expected 0x%0h", name, em);
      end else begin
         check({name, "_msb"}, 32'(q_m.pop_front()), 32'(em));
         check({name, "_lsb"}, 32'(q_l.pop_front()), 32'(el));
      end
   endtask

   initial begin
      int lat, vcnt, fe0;
      logic [15:0] w;

      vecs[0] = '{16'hA53C, 8, 16'hA53C, 16'h3CA5};
      vecs[1] = '{16'h0001, 4, 16'h0001, 16'h8000};
      vecs[2] = '{16'hFFFF, 5, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{16'h8000, 6, 16'h8000, 16'h0001};
      vecs[4] = '{16'h1234, 4, 16'h1234, 16'h2C48};
      vecs[5] = '{16'h0000, 7, 16'h0000, 16'h0000};

      rst = 1'b1; ser_data = 1'b0; ser_strobe = 1'b0; ready_drv = 1'b0; rand_mode = 1'b0;
      tick(3);
      check("rst_word_out_m", 32'(out_m), 0);
      check("rst_word_out_l", 32'(out_l), 0);
      check("rst_flags_m", 32'({valid_m, ferr_m, ovr_m, busy_m}), 0);
      check("rst_flags_l", 32'({valid_l, ferr_l, ovr_l, busy_l}), 0);
      rst = 1'b0;
      tick(2);

      // First word with latency and single-cycle valid measurement
      ready_drv = 1'b1;
      fe0 = fe_m;
      w = 16'hA53C;
      send_bits(w, 15, 8);
      ser_data = w[0];
      tick(1);
      ser_strobe = 1'b1;
      lat = 0; vcnt = 0;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (k == 4) ser_strobe = 1'b0;
         if (valid_m) begin
            vcnt++;
            if (lat == 0) lat = k;
         end
      end
      check("latency", 32'(lat), 5);
      check("valid_cycles", 32'(vcnt), 1);
      expect_word("a53c", 16'hA53C, 16'h3CA5);
      check("a53c_no_ferr", 32'(fe_m - fe0), 0);
      check("a53c_no_ovr", 32'({ovr_m, ovr_l}), 0);

      // Table of independent words at various strobe periods
      for (int i = 0; i < 6; i++) begin
         send_bits(vecs[i].word, 16, vecs[i].period);
         expect_word($sformatf("vec%0d", i), vecs[i].exp_m, vecs[i].exp_l);
         tick(3);
      end

      // Back-to-back words at the minimum strobe period
      send_bits(16'h00FF, 16, 4);
      send_bits(16'hFF00, 16, 4);
      expect_word("b2b_first", 16'h00FF, 16'hFF00);
      expect_word("b2b_second", 16'hFF00, 16'h00FF);

      // Partial frame timeout
      fe0 = fe_m;
      send_bits(16'hABCD, 7, 4);
      check("partial_busy", 32'(busy_m), 1);
      tick(1100);
      check("timeout_ferr_m", 32'(fe_m - fe0), 1);
      check("timeout_ferr_l", 32'(fe_l - fe0), 1);
      check("timeout_busy", 32'({busy_m, busy_l}), 0);
      check("timeout_no_word", 32'(q_m.size()), 0);
      send_bits(16'h1234, 16, 4);
      expect_word("after_timeout", 16'h1234, 16'h2C48);

      // Overrun with a stalled consumer
      ready_drv = 1'b0;
      send_bits(16'h1111, 16, 4);
      send_bits(16'h2222, 16, 4);
      tick(10);
      check("ovr_held_m", 32'(out_m), 32'h1111);
      check("ovr_held_l", 32'(out_l), 32'h8888);
      check("ovr_valid", 32'(valid_m), 1);
      check("ovr_flag", 32'({ovr_m, ovr_l}), 32'h3);
      ready_drv = 1'b1;
      tick(1);
      check("ovr_accept_valid", 32'(valid_m), 0);
      check("ovr_sticky", 32'(ovr_m), 1);
      expect_word("ovr_word", 16'h1111, 16'h8888);

      // Reset mid-frame with a held word
      ready_drv = 1'b0;
      send_bits(16'h5555, 16, 4);
      send_bits(16'hBEEF, 9, 4);
      check("pre_rst_valid", 32'(valid_m), 1);
      check("pre_rst_busy", 32'(busy_m), 1);
      rst = 1'b1;
      tick(1);
      check("rst_mid_word_out", 32'({out_m, out_l}), 0);
      check("rst_mid_flags", 32'({valid_m, ferr_m, ovr_m, busy_m, valid_l, ovr_l, busy_l}), 0);
      rst = 1'b0;
      q_m.delete();
      q_l.delete();
      fe0 = fe_m;
      tick(1100);
      check("rst_no_ferr", 32'(fe_m - fe0), 0);
      ready_drv = 1'b1;
      send_bits(16'hBEEF, 16, 6);
      expect_word("beef", 16'hBEEF, bitrev(16'hBEEF));

      // Randomized words, periods, gaps and consumer backpressure
      rand_mode = 1'b1;
      fe0 = fe_m;
      for (int n = 0; n < 20; n++) begin
         w = 16'($urandom);
         send_bits(w, 16, int'($urandom_range(4, 9)));
         expect_word($sformatf("rand%0d", n), w, bitrev(w));
         tick(int'($urandom_range(0, 15)));
      end
      check("rand_no_ovr", 32'({ovr_m, ovr_l}), 0);
      check("rand_no_ferr", 32'(fe_m - fe0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end

endmodule
